// File: rtl/controlador_rodadas.sv
// controlador_rodadas: round sequencer for the range-measurement game.
// It paces medir pulses to medidor_faixa, programs the BCD window for each
// round, scores every measurement (a timeout is scored as a miss) and
// decides win or loss. All outputs come straight from registers.
module controlador_rodadas #(
    parameter int N_RODADAS   = 4,
    parameter int ACERTOS_REQ = 3,
    parameter int MAX_ERROS   = 5,
    parameter int TIMEOUT     = 3_000_000,
    parameter int INTERVALO   = 5_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        medida_pronta,
    input  logic        dentro,
    output logic        medir,
    output logic [11:0] upperL,
    output logic [11:0] lowerL,
    output logic [2:0]  rodada,
    output logic [2:0]  consecutivos,
    output logic [3:0]  erros,
    output logic        fim,
    output logic        ganhou,
    output logic [3:0]  db_estado
);

    // One shared cycle counter serves both the measurement timeout and the
    // idle interval, so it is sized for the larger of the two.
    localparam int CNT_MAX = (TIMEOUT > INTERVALO) ? TIMEOUT : INTERVALO;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TMO_FIM     = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] INT_FIM     = CNT_W'(INTERVALO - 1);
    localparam logic [2:0]       ULTIMA      = 3'(N_RODADAS - 1);
    localparam logic [2:0]       ACERTOS_LIM = 3'(ACERTOS_REQ);
    localparam logic [3:0]       ERROS_LIM   = 4'(MAX_ERROS);

    typedef enum logic [2:0] {
        INICIAL   = 3'd0,
        PREPARA   = 3'd1,
        MEDE      = 3'd2,
        ESPERA    = 3'd3,
        AVALIA    = 3'd4,
        INTERVALO_E = 3'd5,
        PROXIMA   = 3'd6,
        FIM       = 3'd7
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rodada_q, rodada_d;
    logic [2:0]       consec_q, consec_d;
    logic [3:0]       erros_q, erros_d;
    logic             ganhou_q, ganhou_d;
    logic             dentro_q, dentro_d;
    logic [11:0]      upper_q, upper_d;
    logic [11:0]      lower_q, lower_d;
    logic             medir_q, medir_d;
    logic             fim_q, fim_d;
    logic [3:0]       erros_inc;
    logic [2:0]       consec_inc;

    // Miss counter increments but holds at MAX_ERROS instead of wrapping.
    function automatic logic [3:0] erros_sat(input logic [3:0] e);
        if (e >= ERROS_LIM) begin
            return ERROS_LIM;
        end
        return e + 4'd1;
    endfunction

    // BCD window limit for round r: tens digit is base + r, units and
    // hundreds are zero (10 + 10*r for the lower, 20 + 10*r for the upper).
    function automatic logic [11:0] janela(input logic [2:0] r, input logic [3:0] base);
        return {4'h0, base + {1'b0, r}, 4'h0};
    endfunction

    assign erros_inc  = erros_sat(erros_q);
    assign consec_inc = consec_q + 3'd1;

    // Next-state and datapath update for the round sequencer.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        rodada_d = rodada_q;
        consec_d = consec_q;
        erros_d  = erros_q;
        ganhou_d = ganhou_q;
        dentro_d = dentro_q;
        upper_d  = upper_q;
        lower_d  = lower_q;

        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    rodada_d = 3'd0;
                    consec_d = 3'd0;
                    erros_d  = 4'd0;
                    ganhou_d = 1'b0;
                    estado_d = PREPARA;
                end
            end
            PREPARA: begin
                lower_d  = janela(rodada_q, 4'd1);
                upper_d  = janela(rodada_q, 4'd2);
                consec_d = 3'd0;
                estado_d = MEDE;
            end
            MEDE: begin
                cnt_d    = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                // A completed measurement beats a simultaneous timeout.
                if (medida_pronta) begin
                    dentro_d = dentro;
                    estado_d = AVALIA;
                end else if (cnt_q == TMO_FIM) begin
                    dentro_d = 1'b0;
                    estado_d = AVALIA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            AVALIA: begin
                cnt_d = '0;
                if (dentro_q) begin
                    consec_d = consec_inc;
                    estado_d = (consec_inc == ACERTOS_LIM) ? PROXIMA : INTERVALO_E;
                end else begin
                    consec_d = 3'd0;
                    erros_d  = erros_inc;
                    if (erros_inc == ERROS_LIM) begin
                        ganhou_d = 1'b0;
                        estado_d = FIM;
                    end else begin
                        estado_d = INTERVALO_E;
                    end
                end
            end
            INTERVALO_E: begin
                if (cnt_q == INT_FIM) begin
                    estado_d = MEDE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PROXIMA: begin
                if (rodada_q == ULTIMA) begin
                    ganhou_d = 1'b1;
                    estado_d = FIM;
                end else begin
                    rodada_d = rodada_q + 3'd1;
                    estado_d = PREPARA;
                end
            end
            FIM: begin
                if (iniciar) begin
                    erros_d  = 4'd0;
                    ganhou_d = 1'b0;
                    rodada_d = 3'd0;
                    estado_d = PREPARA;
                end
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase

        // Pulse-style outputs are registered from the state being entered.
        medir_d = (estado_d == MEDE);
        fim_d   = (estado_d == FIM);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            cnt_q    <= '0;
            rodada_q <= 3'd0;
            consec_q <= 3'd0;
            erros_q  <= 4'd0;
            ganhou_q <= 1'b0;
            dentro_q <= 1'b0;
            upper_q  <= 12'h020;
            lower_q  <= 12'h010;
            medir_q  <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            rodada_q <= rodada_d;
            consec_q <= consec_d;
            erros_q  <= erros_d;
            ganhou_q <= ganhou_d;
            dentro_q <= dentro_d;
            upper_q  <= upper_d;
            lower_q  <= lower_d;
            medir_q  <= medir_d;
            fim_q    <= fim_d;
        end
    end

    assign medir        = medir_q;
    assign upperL       = upper_q;
    assign lowerL       = lower_q;
    assign rodada       = rodada_q;
    assign consecutivos = consec_q;
    assign erros        = erros_q;
    assign fim          = fim_q;
    assign ganhou       = ganhou_q;
    assign db_estado    = {1'b0, estado_q};

endmodule

// File: tb/tb_controlador_rodadas.sv
// Directed bench for controlador_rodadas with small timing overrides.
module tb_controlador_rodadas;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iniciar = 1'b0;
    logic        medida_pronta = 1'b0;
    logic        dentro = 1'b0;
    logic        medir;
    logic [11:0] upperL;
    logic [11:0] lowerL;
    logic [2:0]  rodada;
    logic [2:0]  consecutivos;
    logic [3:0]  erros;
    logic        fim;
    logic        ganhou;
    logic [3:0]  db_estado;

    int checks = 0;
    int errors = 0;

    controlador_rodadas #(
        .N_RODADAS  (2),
        .ACERTOS_REQ(2),
        .MAX_ERROS  (3),
        .TIMEOUT    (20),
        .INTERVALO  (5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .medida_pronta(medida_pronta),
        .dentro       (dentro),
        .medir        (medir),
        .upperL       (upperL),
        .lowerL       (lowerL),
        .rodada       (rodada),
        .consecutivos (consecutivos),
        .erros        (erros),
        .fim          (fim),
        .ganhou       (ganhou),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] code, input int budget);
        int n = 0;
        while (db_estado !== code && n < budget) begin
            tick();
            n++;
        end
        check(tag, db_estado, code);
    endtask

    // Wait for ESPERA, deliver one measurement, land in AVALIA.
    task automatic medida(input string tag, input logic d);
        wait_state({tag, "_espera"}, 4'd3, 100);
        medida_pronta = 1'b1;
        dentro = d;
        tick();
        medida_pronta = 1'b0;
        dentro = 1'b0;
        check({tag, "_avalia"}, db_estado, 4'd4);
    endtask

    initial begin
        int n;

        // ---- 1: reset values, async reset mid-ESPERA ----
        tick();
        #3 reset = 1'b1;
        tick();
        check("rst_estado", db_estado, 4'd0);
        check("rst_medir", medir, 1'b0);
        check("rst_lower", lowerL, 12'h010);
        check("rst_upper", upperL, 12'h020);
        check("rst_fim", fim, 1'b0);
        check("rst_ganhou", ganhou, 1'b0);
        check("rst_rodada", rodada, 3'd0);
        check("rst_consec", consecutivos, 3'd0);
        check("rst_erros", erros, 4'd0);

        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("t1_prepara", db_estado, 4'd1);
        tick();
        check("t1_mede", db_estado, 4'd2);
        check("t1_medir_on", medir, 1'b1);
        tick();
        check("t1_espera", db_estado, 4'd3);
        check("t1_medir_off", medir, 1'b0);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        check("t1_async_estado", db_estado, 4'd0);
        check("t1_async_medir", medir, 1'b0);
        #1 reset = 1'b1;
        tick();
        check("t1_rel_lower", lowerL, 12'h010);
        check("t1_rel_upper", upperL, 12'h020);
        check("t1_rel_estado", db_estado, 4'd0);

        // ---- 2: four hits, win ----
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        check("t2_mede0", db_estado, 4'd2);
        check("t2_lower0", lowerL, 12'h010);
        check("t2_upper0", upperL, 12'h020);
        medida("t2_h1", 1'b1);
        tick();
        check("t2_h1_int", db_estado, 4'd5);
        check("t2_h1_consec", consecutivos, 3'd1);
        medida("t2_h2", 1'b1);
        tick();
        check("t2_prox", db_estado, 4'd6);
        check("t2_h2_consec", consecutivos, 3'd2);
        tick();
        check("t2_prep1", db_estado, 4'd1);
        check("t2_rodada1", rodada, 3'd1);
        tick();
        check("t2_mede1", db_estado, 4'd2);
        check("t2_lower1", lowerL, 12'h020);
        check("t2_upper1", upperL, 12'h030);
        check("t2_consec_clr", consecutivos, 3'd0);
        medida("t2_h3", 1'b1);
        medida("t2_h4", 1'b1);
        tick();
        check("t2_prox_fin", db_estado, 4'd6);
        check("t2_fim_early", fim, 1'b0);
        tick();
        check("t2_fim_estado", db_estado, 4'd7);
        check("t2_fim", fim, 1'b1);
        check("t2_ganhou", ganhou, 1'b1);
        check("t2_rodada_fin", rodada, 3'd1);
        check("t2_erros", erros, 4'd0);

        // ---- 6 then 3: restart from FIM, hit/miss/hit/hit ----
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("t6_prepara", db_estado, 4'd1);
        check("t6_erros", erros, 4'd0);
        check("t6_rodada", rodada, 3'd0);
        check("t6_ganhou", ganhou, 1'b0);
        check("t6_fim", fim, 1'b0);
        tick();
        check("t6_medir", medir, 1'b1);
        check("t6_lower", lowerL, 12'h010);
        medida("t3_h1", 1'b1);
        tick();
        check("t3_h1_consec", consecutivos, 3'd1);
        medida("t3_m1", 1'b0);
        tick();
        check("t3_m1_int", db_estado, 4'd5);
        check("t3_m1_consec", consecutivos, 3'd0);
        check("t3_m1_erros", erros, 4'd1);
        medida("t3_h2", 1'b1);
        tick();
        check("t3_h2_consec", consecutivos, 3'd1);
        check("t3_h2_rodada", rodada, 3'd0);
        medida("t3_h3", 1'b1);
        tick();
        check("t3_prox", db_estado, 4'd6);
        tick();
        check("t3_rodada1", rodada, 3'd1);
        medida("t3_m2", 1'b0);
        tick();
        check("t3_m2_erros", erros, 4'd2);
        medida("t3_m3", 1'b0);
        tick();
        check("t3_lose_estado", db_estado, 4'd7);
        check("t3_lose_fim", fim, 1'b1);
        check("t3_lose_ganhou", ganhou, 1'b0);
        check("t3_lose_erros", erros, 4'd3);

        // ---- 4: three timeouts ----
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (db_estado === 4'd3 && n < 100) begin
                tick();
                n++;
            end
            check("t4_espera_len", n, 20);
            check("t4_avalia", db_estado, 4'd4);
            tick();
            check("t4_erros", erros, 4'(k + 1));
            if (k < 2) begin
                check("t4_intervalo", db_estado, 4'd5);
                n = 0;
                while (db_estado === 4'd5 && n < 100) begin
                    tick();
                    n++;
                end
                check("t4_interv_len", n, 5);
                check("t4_medir", medir, 1'b1);
                tick();
            end
        end
        check("t4_fim_estado", db_estado, 4'd7);
        check("t4_fim", fim, 1'b1);
        check("t4_ganhou", ganhou, 1'b0);
        check("t4_rodada", rodada, 3'd0);

        // ---- 5: pulse on the timeout cycle, stray pulses, reset in MEDE ----
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        tick();
        repeat (19) tick();
        check("t5_still_espera", db_estado, 4'd3);
        medida_pronta = 1'b1;
        dentro = 1'b1;
        tick();
        medida_pronta = 1'b0;
        dentro = 1'b0;
        check("t5_avalia", db_estado, 4'd4);
        tick();
        check("t5_consec", consecutivos, 3'd1);
        check("t5_erros", erros, 4'd0);
        medida_pronta = 1'b1;
        dentro = 1'b0;
        iniciar = 1'b1;
        repeat (3) tick();
        medida_pronta = 1'b0;
        iniciar = 1'b0;
        check("t5_stray_estado", db_estado, 4'd5);
        check("t5_stray_consec", consecutivos, 3'd1);
        check("t5_stray_erros", erros, 4'd0);
        check("t5_stray_rodada", rodada, 3'd0);
        wait_state("t5_mede", 4'd2, 20);
        check("t5_medir", medir, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_medir", medir, 1'b0);
        check("t5_rst_estado", db_estado, 4'd0);
        check("t5_rst_consec", consecutivos, 3'd0);
        #1 reset = 1'b1;
        tick();
        check("t5_rel_estado", db_estado, 4'd0);
        check("t5_rel_upper", upperL, 12'h020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
